// File: rtl/ps2_key_event_tracker_if.sv
// Byte stream in and key-event stream out of the PS/2 key event tracker.
interface ps2_key_event_tracker_if #(
  parameter int IDXW = 5,
  parameter int CNTW = 4
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            event_valid;
  logic [IDXW:0]   event_data;
  logic            event_ready;
  logic [CNTW-1:0] event_count;

  modport master (
    input  rx_data, rx_valid, event_ready,
    output event_valid, event_data, event_count
  );

  modport slave (
    output rx_data, rx_valid, event_ready,
    input  event_valid, event_data, event_count
  );
endinterface

// File: rtl/ps2_key_event_tracker.sv
// Decodes PS/2 set-2 make/break bytes into held-key state plus a {release,index} event FIFO.
// One cycle rx_valid -> state/pulse/push; a push into a full FIFO with no pop is dropped and flagged.
module ps2_key_event_tracker #(
  parameter int NUM_KEYS = 29,
  parameter logic [NUM_KEYS*8-1:0] KEY_MAP = {
    8'h29, 8'h5D, 8'h5B, 8'h54, 8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35, 8'h2C,
    8'h2D, 8'h24, 8'h1D, 8'h15, 8'h0D, 8'h66, 8'h55, 8'h4E, 8'h45, 8'h46,
    8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h0E},
  parameter int EVENT_DEPTH = 8,
  parameter bit IGNORE_EXTENDED = 1'b1,
  localparam int IDXW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int PTRW = $clog2(EVENT_DEPTH),
  localparam int CNTW = PTRW + 1
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  ps2_key_event_tracker_if.master evt,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic                  any_key_down,
  output logic                  key_press_pulse,
  output logic                  key_release_pulse,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } decState_t;

  decState_t stateQ, stateD;
  logic      codeDone, codeBreak, codeExt;

  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD    = stateQ;
    codeDone  = 1'b0;
    codeBreak = 1'b0;
    codeExt   = 1'b0;
    if (evt.rx_valid) begin
      case (stateQ)
        IDLE: begin
          if (evt.rx_data == 8'hF0)      stateD = BREAK;
          else if (evt.rx_data == 8'hE0) stateD = EXT;
          else                           codeDone = 1'b1;
        end
        EXT: begin
          if (evt.rx_data == 8'hF0)      stateD = EXT_BREAK;
          else if (evt.rx_data == 8'hE0) stateD = EXT;
          else begin
            codeDone = 1'b1;
            codeExt  = 1'b1;
            stateD   = IDLE;
          end
        end
        BREAK: begin
          if (evt.rx_data == 8'hF0)      stateD = BREAK;
          else if (evt.rx_data == 8'hE0) stateD = EXT_BREAK;
          else begin
            codeDone  = 1'b1;
            codeBreak = 1'b1;
            stateD    = IDLE;
          end
        end
        EXT_BREAK: begin
          if (evt.rx_data != 8'hF0 && evt.rx_data != 8'hE0) begin
            codeDone  = 1'b1;
            codeBreak = 1'b1;
            codeExt   = 1'b1;
            stateD    = IDLE;
          end
        end
        default: stateD = IDLE;
      endcase
    end
  end

  // Descending scan so the lowest matching map entry is the one left standing.
  logic            hit;
  logic [IDXW-1:0] hitIdx;
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_MAP[8*i +: 8] == evt.rx_data) begin
        hit    = 1'b1;
        hitIdx = IDXW'(i);
      end
    end
  end

  logic extBlocked, keyHeld, eventFire;
  assign extBlocked = codeExt && IGNORE_EXTENDED;
  assign keyHeld    = key_state[hitIdx];
  // Typematic repeats and stray breaks fail the held/released test and vanish here.
  assign eventFire  = codeDone && hit && !extBlocked && (codeBreak ? keyHeld : !keyHeld);

  logic [NUM_KEYS-1:0] keyStateD;
  always_comb begin
    keyStateD = key_state;
    if (eventFire) keyStateD[hitIdx] = !codeBreak;
  end

  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      key_state         <= '0;
      key_press_pulse   <= 1'b0;
      key_release_pulse <= 1'b0;
    end else begin
      key_state         <= keyStateD;
      key_press_pulse   <= eventFire && !codeBreak;
      key_release_pulse <= eventFire && codeBreak;
    end
  end

  assign any_key_down = |key_state;

  logic [IDXW:0]   evMem [EVENT_DEPTH];
  logic [PTRW-1:0] wrPtr, rdPtr;
  logic [CNTW-1:0] countQ;
  logic            fifoFull, doPop, doPush, dropEvent;

  assign fifoFull  = (countQ == CNTW'(EVENT_DEPTH));
  assign doPop     = evt.event_ready && (countQ != '0);
  // When full, a same-cycle pop frees the head slot, which is exactly where wrPtr points.
  assign doPush    = eventFire && (!fifoFull || doPop);
  assign dropEvent = eventFire && fifoFull && !doPop;

  always_ff @(posedge CLOCK_50) begin
    if (doPush) evMem[wrPtr] <= {codeBreak, hitIdx};
  end

  always_ff @(posedge CLOCK_50 or posedge resetn) begin
    if (resetn) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      countQ   <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
      if (dropEvent)           overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign evt.event_valid = (countQ != '0);
  assign evt.event_data  = evMem[rdPtr];
  assign evt.event_count = countQ;

endmodule

// File: tb/tb_ps2_key_event_tracker.sv
// Directed bench for ps2_key_event_tracker with default parameters.
module tb_ps2_key_event_tracker;
  localparam int NK   = 29;
  localparam int IDXW = 5;
  localparam int CNTW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_overflow = 1'b0;
  logic [NK-1:0] key_state;
  logic          any_key_down, key_press_pulse, key_release_pulse, overflow;
  int            vecs = 0;
  int            errs = 0;

  ps2_key_event_tracker_if #(.IDXW(IDXW), .CNTW(CNTW)) evt();

  ps2_key_event_tracker dut (
    .CLOCK_50(clk), .resetn(rst), .evt(evt),
    .key_state(key_state), .any_key_down(any_key_down),
    .key_press_pulse(key_press_pulse), .key_release_pulse(key_release_pulse),
    .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic [7:0] b, input logic v, input logic rdy, input logic clr);
    @(negedge clk);
    evt.rx_data = b; evt.rx_valid = v; evt.event_ready = rdy; clear_overflow = clr;
    @(negedge clk);
    evt.rx_valid = 1'b0; evt.event_ready = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic flush();
    for (int i = 0; i < 16 && evt.event_valid; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vecs++; if (key_state !== '0) begin errs++; $display("FAIL rst_keys got %h want 0", key_state); end
    vecs++; if ({any_key_down, key_press_pulse, key_release_pulse, overflow} !== 4'b0) begin errs++; $display("FAIL rst_flags got %b want 0000", {any_key_down, key_press_pulse, key_release_pulse, overflow}); end
    vecs++; if ({evt.event_valid, evt.event_count} !== 5'b0) begin errs++; $display("FAIL rst_fifo got %b want 00000", {evt.event_valid, evt.event_count}); end
    rst = 1'b0;
    cyc(8'h0E, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_state !== NK'(1)) begin errs++; $display("FAIL pre_async got %h want 1", key_state); end
    @(negedge clk); #3 rst = 1'b1; #1;
    vecs++; if ({key_state, any_key_down, evt.event_count} !== '0) begin errs++; $display("FAIL async_rst got %h/%b/%0d want 0", key_state, any_key_down, evt.event_count); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_make_break();
    cyc(8'h15, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_state !== (NK'(1) << 15)) begin errs++; $display("FAIL make_state got %h want %h", key_state, NK'(1) << 15); end
    vecs++; if ({key_press_pulse, key_release_pulse, any_key_down} !== 3'b101) begin errs++; $display("FAIL make_pulse got %b want 101", {key_press_pulse, key_release_pulse, any_key_down}); end
    vecs++; if ({evt.event_valid, evt.event_data, evt.event_count} !== {1'b1, 6'h0F, 4'd1}) begin errs++; $display("FAIL make_event got %b/%h/%0d want 1/0f/1", evt.event_valid, evt.event_data, evt.event_count); end
    @(negedge clk);
    vecs++; if (key_press_pulse !== 1'b0) begin errs++; $display("FAIL make_pulse_width got %b want 0", key_press_pulse); end
    flush();
    cyc(8'hF0, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_state !== (NK'(1) << 15)) begin errs++; $display("FAIL f0_nochange got %h want %h", key_state, NK'(1) << 15); end
    cyc(8'h15, 1'b1, 1'b0, 1'b0);
    vecs++; if ({key_state, any_key_down} !== '0) begin errs++; $display("FAIL break_state got %h want 0", key_state); end
    vecs++; if ({key_press_pulse, key_release_pulse} !== 2'b01) begin errs++; $display("FAIL break_pulse got %b want 01", {key_press_pulse, key_release_pulse}); end
    vecs++; if (evt.event_data !== 6'h2F) begin errs++; $display("FAIL break_event got %h want 2f", evt.event_data); end
    @(negedge clk);
    vecs++; if (key_release_pulse !== 1'b0) begin errs++; $display("FAIL break_pulse_width got %b want 0", key_release_pulse); end
    flush();
  endtask

  task automatic test_typematic();
    cyc(8'h15, 1'b1, 1'b0, 1'b0);
    cyc(8'h15, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_press_pulse !== 1'b0) begin errs++; $display("FAIL typ_pulse got %b want 0", key_press_pulse); end
    cyc(8'h15, 1'b1, 1'b0, 1'b0);
    vecs++; if (evt.event_count !== 4'd1) begin errs++; $display("FAIL typ_count got %0d want 1", evt.event_count); end
    flush();
    cyc(8'hF0, 1'b1, 1'b0, 1'b0); cyc(8'h15, 1'b1, 1'b0, 1'b0);
    cyc(8'hF0, 1'b1, 1'b0, 1'b0); cyc(8'h15, 1'b1, 1'b0, 1'b0);
    vecs++; if ({key_state, evt.event_count} !== {NK'(0), 4'd1}) begin errs++; $display("FAIL dbl_break got %h/%0d want 0/1", key_state, evt.event_count); end
    flush();
  endtask

  task automatic test_extended();
    cyc(8'hE0, 1'b1, 1'b0, 1'b0); cyc(8'h75, 1'b1, 1'b0, 1'b0);
    cyc(8'hE0, 1'b1, 1'b0, 1'b0); cyc(8'hF0, 1'b1, 1'b0, 1'b0); cyc(8'h75, 1'b1, 1'b0, 1'b0);
    cyc(8'hE0, 1'b1, 1'b0, 1'b0); cyc(8'h15, 1'b1, 1'b0, 1'b0);
    vecs++; if ({key_state, evt.event_count} !== '0) begin errs++; $display("FAIL ext_ignored got %h/%0d want 0/0", key_state, evt.event_count); end
    cyc(8'h29, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_state !== (NK'(1) << 28)) begin errs++; $display("FAIL ext_then_make got %h want %h", key_state, NK'(1) << 28); end
    flush();
  endtask

  task automatic test_unmapped();
    cyc(8'hAA, 1'b1, 1'b0, 1'b0); cyc(8'hFA, 1'b1, 1'b0, 1'b0);
    cyc(8'hF0, 1'b1, 1'b0, 1'b0); cyc(8'hFE, 1'b1, 1'b0, 1'b0);
    vecs++; if ({key_state, evt.event_count} !== {NK'(1) << 28, 4'd0}) begin errs++; $display("FAIL unmapped got %h/%0d want %h/0", key_state, evt.event_count, NK'(1) << 28); end
    cyc(8'h0E, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_state !== ((NK'(1) << 28) | NK'(1))) begin errs++; $display("FAIL unmapped_idle got %h want %h", key_state, (NK'(1) << 28) | NK'(1)); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [10];
    codes = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h45};
    doReset();
    for (int i = 0; i < 8; i++) cyc(codes[i], 1'b1, 1'b0, 1'b0);
    vecs++; if ({evt.event_count, overflow} !== {4'd8, 1'b0}) begin errs++; $display("FAIL fill8 got %0d/%b want 8/0", evt.event_count, overflow); end
    cyc(codes[8], 1'b1, 1'b0, 1'b0);
    vecs++; if ({evt.event_count, overflow} !== {4'd8, 1'b1}) begin errs++; $display("FAIL ovf_set got %0d/%b want 8/1", evt.event_count, overflow); end
    vecs++; if (evt.event_data !== 6'h00) begin errs++; $display("FAIL ovf_head got %h want 00", evt.event_data); end
    vecs++; if (key_state !== NK'(29'h1FF)) begin errs++; $display("FAIL ovf_keys got %h want 1ff", key_state); end
    cyc(codes[9], 1'b1, 1'b0, 1'b1);
    vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL clr_vs_ovf got %b want 1", overflow); end
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] heads [8];
    heads = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09};
    cyc(8'h46, 1'b1, 1'b1, 1'b0);
    vecs++; if ({evt.event_count, overflow, evt.event_data} !== {4'd8, 1'b0, 6'h01}) begin errs++; $display("FAIL full_pushpop got %0d/%b/%h want 8/0/01", evt.event_count, overflow, evt.event_data); end
    for (int i = 0; i < 8; i++) begin
      vecs++; if (evt.event_data !== heads[i]) begin errs++; $display("FAIL drain_%0d got %h want %h", i, evt.event_data, heads[i]); end
      cyc(8'h00, 1'b0, 1'b1, 1'b0);
    end
    vecs++; if ({evt.event_valid, evt.event_count} !== 5'b0) begin errs++; $display("FAIL drained got %b/%0d want 0/0", evt.event_valid, evt.event_count); end
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    vecs++; if (evt.event_count !== 4'd0) begin errs++; $display("FAIL pop_empty got %0d want 0", evt.event_count); end
    cyc(8'h0D, 1'b1, 1'b0, 1'b0);
    vecs++; if ({evt.event_count, evt.event_data} !== {4'd1, 6'h0E}) begin errs++; $display("FAIL wrap_push got %0d/%h want 1/0e", evt.event_count, evt.event_data); end
    flush();
  endtask

  task automatic test_reset_mid();
    doReset();
    cyc(8'hF0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1; evt.rx_data = 8'h0E; evt.rx_valid = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0; evt.rx_valid = 1'b0;
    vecs++; if ({key_state, evt.event_count} !== '0) begin errs++; $display("FAIL rx_in_reset got %h/%0d want 0/0", key_state, evt.event_count); end
    cyc(8'h16, 1'b1, 1'b0, 1'b0);
    vecs++; if (key_state !== NK'(2)) begin errs++; $display("FAIL prefix_discard got %h want 2", key_state); end
    vecs++; if ({key_press_pulse, evt.event_data} !== {1'b1, 6'h01}) begin errs++; $display("FAIL prefix_event got %b/%h want 1/01", key_press_pulse, evt.event_data); end
  endtask

  initial begin
    evt.rx_data = 8'h00; evt.rx_valid = 1'b0; evt.event_ready = 1'b0;
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_unmapped();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_tracker.md
PS2_KEY_EVENT_TRACKER -- requirements
Module: ps2_key_event_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 29, number of tracked keys (1..64).
REQ-002 Parameter KEY_MAP, NUM_KEYS*8 bits, scan code of key i in bits [8i+7:8i]; default entries 0..28 = 0E,16,1E,26,25,2E,36,3D,3E,46,45,4E,55,66,0D,15,1D,24,2D,2C,35,3C,43,44,4D,54,5B,5D,29.
REQ-003 Parameter EVENT_DEPTH, default 8, event FIFO depth (power of 2, >=2).
REQ-004 Parameter IGNORE_EXTENDED, default 1; 1 = E0-prefixed codes never change state, 0 = prefix stripped and code mapped normally.
REQ-005 Derived IDXW = clog2(NUM_KEYS), minimum 1.
REQ-006 CLOCK_50  input  1  sole clock, all logic on rising edge.
REQ-007 resetn  input  1  asynchronous, active-high reset (asserted = 1, despite name).
REQ-008 rx_data  input  8  received PS2 byte, valid only with rx_valid.
REQ-009 rx_valid  input  1  one-cycle strobe, synchronous to CLOCK_50.
REQ-010 key_state  output  NUM_KEYS  bit i = 1 while key i held.
REQ-011 any_key_down  output  1  OR-reduction of key_state.
REQ-012 key_press_pulse  output  1  one-cycle pulse on any 0->1 key_state transition.
REQ-013 key_release_pulse  output  1  one-cycle pulse on any 1->0 key_state transition.
REQ-014 event_valid  output  1  FIFO non-empty.
REQ-015 event_data  output  IDXW+1  head entry {release, key_index}, show-ahead.
REQ-016 event_ready  input  1  pop head when event_valid && event_ready.
REQ-017 event_count  output  clog2(EVENT_DEPTH)+1  entries held.
REQ-018 overflow  output  1  sticky, an event was dropped.
REQ-019 clear_overflow  input  1  synchronous clear of overflow.

Function
REQ-020 Decoder FSM states: IDLE, BREAK, EXT, EXT_BREAK; advances only on rx_valid.
REQ-021 IDLE: F0 -> BREAK; E0 -> EXT; other byte = make code, stay IDLE.
REQ-022 EXT: F0 -> EXT_BREAK; E0 -> EXT; other = extended make, -> IDLE.
REQ-023 BREAK: F0 -> BREAK; E0 -> EXT_BREAK; other = break code, -> IDLE.
REQ-024 EXT_BREAK: F0/E0 -> EXT_BREAK; other = extended break, -> IDLE.
REQ-025 Make code matching KEY_MAP entry i sets key_state[i]; break clears it; lowest matching index wins on duplicate map entries.
REQ-026 Unmapped codes (incl. AA, FA, FE) change no key_state, emit no event, still return FSM to IDLE.
REQ-027 Extended make/break with IGNORE_EXTENDED=1: no state change, no event.
REQ-028 Typematic filter: make of already-held key, or break of already-released key, emits no pulse and no event.
REQ-029 Latency: rx_valid on cycle N -> key_state, pulses, FIFO push visible cycle N+1.
REQ-030 Each key_state transition pushes {release (1=break), index} into FIFO.
REQ-031 Push when full and no pop: event dropped, FIFO unchanged, overflow set next cycle.
REQ-032 Push and pop same cycle: both performed, event_count unchanged, including when full.
REQ-033 Pop when empty ignored; event_data undefined when event_valid = 0.
REQ-034 FIFO pointers wrap modulo EVENT_DEPTH.
REQ-035 clear_overflow and a simultaneous overflow event: overflow remains set.

Reset
REQ-036 resetn asserted: FSM IDLE, key_state 0, any_key_down 0, both pulses 0, FIFO empty, event_valid 0, event_count 0, overflow 0, immediately (asynchronous).
REQ-037 Reset mid-sequence (after F0/E0 received) discards prefix; first byte after release decoded from IDLE.
REQ-038 rx_valid during reset ignored.

Verification
REQ-039 Bytes 15 -> key_state[15]=1, key_press_pulse 1 cycle, event_data {0,15}; then F0,15 -> key_state[15]=0, key_release_pulse, event {1,15}.
REQ-040 Bytes 15,15,15 (typematic) -> exactly one event, event_count 1.
REQ-041 Bytes E0,75 and E0,F0,75 with IGNORE_EXTENDED=1 -> key_state 0, event_count 0; then 29 -> key_state[28]=1.
REQ-042 event_ready=0, 9 distinct makes, EVENT_DEPTH=8 -> event_count 8, overflow 1, head {0,first key}; clear_overflow -> overflow 0.
REQ-043 FIFO full, make and event_ready=1 same cycle -> event_count stays 8, new event at tail, overflow 0.
REQ-044 Bytes F0 then resetn pulse then 16 -> key_state[1]=1 (treated as make).
